pwm_peripheral: RTL and testbench

Downstream consumer of the SPI register bank. Takes the five configuration bytes (output enables, PWM enables, duty cycle) and drives 16 output pins. Each pin is either off, statically high, or driven by a shared 8-bit PWM waveform (~3 kHz at 10 MHz clk). Sits between the SPI peripheral's register outputs and the chip's uo_out/uio_out pins.

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_timebase.sv | 37 +++
 rtl/pwm_peripheral.sv | 91 +++++++++
 tb/tb_pwm_peripheral.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output block.
package pwm_pkg;
  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int NUM_CH = 16;
  localparam int CLK_DIV_DEFAULT = 13;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler producing a tick every CLK_DIV clocks and an
// 8-bit phase counter that wraps every 256 ticks.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DIV_W   = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  output pwm_cnt_t o_pwm_cnt,
  output logic     o_tick,
  output logic     o_wrap
);

  logic [DIV_W-1:0] r_div_cnt;
  pwm_cnt_t         r_pwm_cnt;
  logic             w_tick;

  assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_CNT_W'(1);
      end
    end
  end

  assign o_pwm_cnt = r_pwm_cnt;
  assign o_tick    = w_tick;
  assign o_wrap    = w_tick && (r_pwm_cnt == DUTY_FULL);
endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin off, static high, or following the shared PWM level.
// Define PWM_DUTY_SHADOW_EN to latch the duty only at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  pwm_cnt_t w_pwm_cnt;
  logic     w_tick;
  logic     w_wrap;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_timebase (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_pwm_cnt (w_pwm_cnt),
    .o_tick    (w_tick),
    .o_wrap    (w_wrap)
  );

  pwm_cnt_t w_duty_eff;

`ifdef PWM_DUTY_SHADOW_EN
  pwm_cnt_t r_duty_shadow;
  logic     r_shadow_init;

  // First clock after reset primes the shadow so the first period is not stuck at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_shadow <= '0;
      r_shadow_init <= 1'b1;
    end else begin
      if (r_shadow_init || w_wrap) begin
        r_duty_shadow <= pwm_duty_cycle;
      end
      r_shadow_init <= 1'b0;
    end
  end

  assign w_duty_eff = r_duty_shadow;
`else
  assign w_duty_eff = pwm_duty_cycle;
`endif

  logic              w_level;
  logic [NUM_CH-1:0] w_en_out;
  logic [NUM_CH-1:0] w_en_pwm;
  logic [NUM_CH-1:0] w_out_nxt;
  logic [NUM_CH-1:0] r_out;
  logic              r_period_start;

  assign w_level  = (w_duty_eff == DUTY_FULL) || (w_pwm_cnt < w_duty_eff);
  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_out_nxt[i] = w_en_out[i] & (~w_en_pwm[i] | w_level);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_out          <= w_out_nxt;
      // A new period begins on the clock after the tick that wraps 255 -> 0.
      r_period_start <= w_tick & w_wrap;
    end
  end

  assign out_7_0      = r_out[7:0];
  assign out_15_8     = r_out[15:8];
  assign period_start = r_period_start;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomised and directed bench for pwm_peripheral against a cycle-count based model.
module tb_pwm_peripheral;
  localparam int D0 = 13;
  localparam int P0 = 256 * D0;
  localparam int D1 = 1;
  localparam int P1 = 256 * D1;
`ifdef PWM_DUTY_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [7:0]  o0_lo, o0_hi, o1_lo, o1_hi;
  logic        ps0, ps1;
  logic [15:0] out0, out1;

  int checks = 0;
  int failures = 0;
  int nprint = 0;

  always #5 clk = ~clk;

  assign out0 = {o0_hi, o0_lo};
  assign out1 = {o1_hi, o1_lo};

  pwm_peripheral #(.CLK_DIV(D0), .DIV_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty),
    .out_7_0(o0_lo), .out_15_8(o0_hi), .period_start(ps0)
  );

  pwm_peripheral #(.CLK_DIV(D1), .DIV_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty),
    .out_7_0(o1_lo), .out_15_8(o1_hi), .period_start(ps1)
  );

  // Pin values implied by n clocks elapsed since reset release.
  function automatic logic [15:0] pins(input int n, input int d, input logic [7:0] de,
                                       input logic [15:0] eo, input logic [15:0] ep);
    logic [15:0] r;
    int          pc;
    logic        lvl;
    pc  = (n / d) % 256;
    lvl = (de == 8'hFF) || (pc < int'(de));
    for (int i = 0; i < 16; i++) r[i] = eo[i] ? (ep[i] ? lvl : 1'b1) : 1'b0;
    return r;
  endfunction

  int          m0_n, m1_n;
  logic [15:0] m0_out, m1_out;
  logic        m0_ps, m1_ps;
  logic [7:0]  m0_sh, m1_sh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_n = 0; m0_out = '0; m0_ps = 1'b0; m0_sh = '0;
      m1_n = 0; m1_out = '0; m1_ps = 1'b0; m1_sh = '0;
    end else begin
      m0_out = pins(m0_n, D0, SHADOW ? m0_sh : duty, en_out, en_pwm);
      if (m0_n == 0 || (m0_n % P0) == P0 - 1) m0_sh = duty;
      m0_n++;
      m0_ps = (m0_n % P0) == 0;
      m1_out = pins(m1_n, D1, SHADOW ? m1_sh : duty, en_out, en_pwm);
      if (m1_n == 0 || (m1_n % P1) == P1 - 1) m1_sh = duty;
      m1_n++;
      m1_ps = (m1_n % P1) == 0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({out0, ps0} !== {m0_out, m0_ps}) begin
      failures++;
      if (nprint < 20) $display("FAIL model_div13 @%0t: out=%h ps=%b expected out=%h ps=%b",
                                $time, out0, ps0, m0_out, m0_ps);
      nprint++;
    end
    checks++;
    if ({out1, ps1} !== {m1_out, m1_ps}) begin
      failures++;
      if (nprint < 20) $display("FAIL model_div1 @%0t: out=%h ps=%b expected out=%h ps=%b",
                                $time, out1, ps1, m1_out, m1_ps);
      nprint++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(input bit sel, output int waited);
    waited = 0;
    for (int i = 0; i < 2 * P0 + 16; i++) begin
      @(negedge clk);
      waited++;
      if (sel ? ps1 : ps0) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_period_start: no pulse within %0d cycles", waited);
  endtask

  task automatic count_high(input bit sel, input int ch_a, input int ch_b, input int ncyc,
                            output int ha, output int hb);
    ha = 0;
    hb = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      ha += int'(sel ? out1[ch_a] : out0[ch_a]);
      hb += int'(sel ? out1[ch_b] : out0[ch_b]);
    end
  endtask

  task automatic measure(input string name, input bit sel, input logic [7:0] d, input int exp);
    int w, ha, hb;
    duty = d;
    wait_ps(sel, w);
    count_high(sel, 0, 0, sel ? P1 : P0, ha, hb);
    chk(name, ha, exp);
  endtask

  initial begin
    int w, ha, hb, first0, first1;
    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    repeat (3) @(negedge clk);
    chk("reset_out_div13", out0, 0);
    chk("reset_ps_div13", ps0, 0);
    chk("reset_out_div1", out1, 0);

    en_out = 16'h00A5;
    en_pwm = 16'h0000;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("static_out_7_0", out0[7:0], 8'hA5);
    chk("static_out_15_8", out0[15:8], 0);
    en_out = 16'h005A;
    @(negedge clk);
    chk("static_change", out0[7:0], 8'h5A);

    first0 = 0;
    first1 = 0;
    for (int k = 3; k < P0 + 64 && first0 == 0; k++) begin
      @(negedge clk);
      if (ps1 && first1 == 0) first1 = k;
      if (ps0) first0 = k;
    end
    chk("first_period_start_div13", first0, P0);
    chk("first_period_start_div1", first1, P1);

    en_out = 16'h0001;
    en_pwm = 16'h0001;
    measure("duty_00_high", 1'b0, 8'h00, 0);
    measure("duty_80_high", 1'b0, 8'h80, 1664);
    measure("duty_01_high", 1'b0, 8'h01, 13);
    measure("duty_FF_high", 1'b0, 8'hFF, P0);

    duty = 8'h20;
    wait_ps(1'b0, w);
    count_high(1'b0, 0, 0, 1300, ha, hb);
    chk("midchange_first_part", ha, 416);
    duty = 8'hC0;
    count_high(1'b0, 0, 0, P0 - 1300, ha, hb);
    chk("midchange_rest", ha, SHADOW ? 0 : 1196);
    count_high(1'b0, 0, 0, P0, ha, hb);
    chk("midchange_next_period", ha, 2496);

    en_out = 16'hFFFF;
    en_pwm = 16'h00F0;
    duty   = 8'h40;
    wait_ps(1'b0, w);
    count_high(1'b0, 4, 0, P0, ha, hb);
    chk("mixed_ch4_high", ha, 832);
    chk("mixed_ch0_static", hb, P0);

    en_out = 16'h0001;
    en_pwm = 16'h0001;
    measure("div1_duty_03_high", 1'b1, 8'h03, 3);
    wait_ps(1'b1, w);
    chk("div1_period", w, P1);

    repeat (1000) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out", out0, 0);
    chk("midreset_ps", ps0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps(1'b0, w);
    chk("restart_period_start", w, P0);

    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      if ($urandom_range(63) == 0) begin
        case ($urandom_range(2))
          0: en_out = 16'($urandom);
          1: en_pwm = 16'($urandom);
          default: begin
            case ($urandom_range(3))
              0: duty = 8'h00;
              1: duty = 8'hFF;
              default: duty = 8'($urandom);
            endcase
          end
        endcase
      end
      if (c == 7000) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
